shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle controller for the combinational 32-bit Shift datapath (ctrl 00=SLL, 01=SRL, 10=SRA).
//  Accepts one shift request over a valid/ready handshake and breaks shamt into steps of at most MAX_STEP bits.
//  Drives the shifter once per cycle and returns the result over a valid/ready response channel.
//  Sits between the EX-stage control and the Shift unit, so a narrow per-cycle shift bounds timing.
// PARAMETERS
//  MAX_STEP  8  max bits shifted per cycle; legal range 1..31.
// PORTS
//  clk        in   1   system clock; all state changes on the rising edge
//  reset_n    in   1   asynchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   high only in IDLE; request accepted when req_valid && req_ready
//  req_op     in   2   00 SLL, 01 SRL, 10 SRA, 11 ROTR (ROTR only with SHIFT_ROTATE_EN)
//  req_shamt  in   5   total shift amount 0..31
//  req_data   in   32  operand
//  rsp_valid  out  1   result present
//  rsp_ready  in   1   consumer accepts result
//  rsp_data   out  32  result
//  busy       out  1   state != IDLE
//  sh_ctrl    out  2   to Shift unit shift_ctrl
//  sh_shamt   out  5   to Shift unit shamt
//  sh_in      out  32  to Shift unit shift_in
//  sh_out     in   32  from Shift unit shift_out (combinational, same cycle)
// BEHAVIOUR
//  - States: IDLE -> RUN -> DONE -> IDLE. IDLE -> DONE directly when shamt==0 or op=11 passthrough.
//  - Accept edge T: latch op, rem<=shamt, acc<=req_data.
//  - RUN, per cycle:
//      step = min(rem, MAX_STEP); sh_ctrl=op, sh_shamt=step, sh_in=acc
//      acc<=sh_out; rem<=rem-step
//      leave to DONE on the edge where rem-step==0
//  - Latency: k=ceil(shamt/MAX_STEP) RUN cycles; rsp_valid rises at edge T+k (k=0: at edge T itself).
//  - Outside RUN: sh_ctrl=00, sh_shamt=0, sh_in=acc (shifter idle, no glitch dependence).
//  - DONE:
//      rsp_valid=1, rsp_data=acc
//      both held stable until rsp_valid && rsp_ready; that edge returns to IDLE
//  - One transaction in flight: req_ready=0 in RUN and DONE; req_valid there is ignored, nothing queued.
//      A new request can be accepted on the cycle after the response handshake.
//  - SRA sign fill is preserved across steps because each step is an SRA of the partial result.
//  - Async reset, any time including mid-RUN or DONE: abort, no response.
//      state=IDLE, acc=0, rem=0
//      req_ready=1, rsp_valid=0, rsp_data=0, busy=0, sh_*=0
//  - rsp_ready is ignored outside DONE.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined: op 11 = rotate right by n.
//  - Phase A: SRL chunks of the original -> acc.
//  - Phase B: SLL chunks of the original (held in orig reg) by 32-n -> tmp.
//  - rsp_data = acc|tmp.
//  - n=0: passthrough, k=0.
//  - Otherwise k = ceil(n/MAX_STEP) + ceil((32-n)/MAX_STEP).
//  - Adds states ROT_A and ROT_B plus orig/tmp registers.
//  SHIFT_ROTATE_EN undefined: op 11 returns req_data unchanged with k=0; no extra registers.
// TESTING (MAX_STEP=8)
//  - SLL 0x0000000A by 3 -> rsp_data 0x00000050; k=1; one cycle with sh_shamt=3.
//  - SRL 0xFFFFFFEF by 31 -> 0x00000001; k=4; sh_shamt sequence 8,8,8,7.
//  - SRA 0xFFFFFFEF by 10 -> 0xFFFFFFFF; k=2 (8,2); SLL by 0 -> data unchanged, rsp_valid at accept edge.
//  - Backpressure: rsp_ready=0 for 3 cycles in DONE.
//      rsp_data stable, req_ready=0, second req_valid ignored.
//      After the handshake it is accepted and completes correctly.
//  - reset_n low during RUN of SRL by 31 -> all outputs reset values immediately, no rsp_valid.
//      Next request SLL 1 by 1 -> 0x00000002.
//  - SHIFT_ROTATE_EN: ROTR 0x0000000B by 1 -> 0x80000005; k=5.
//      Without the macro, same stimulus -> 0x0000000B, k=0.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle sequencer that drives a combinational 32-bit shifter in chunks of at most MAX_STEP bits.
// Optional feature macro: SHIFT_ROTATE_EN (op 11 = rotate right); without it op 11 is a passthrough.
module shift_sequencer #(
  parameter int MAX_STEP = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [1:0]  sh_ctrl,
  output logic [4:0]  sh_shamt,
  output logic [31:0] sh_in,
  input  logic [31:0] sh_out
);

  localparam logic [4:0] STEP_MAX = 5'(MAX_STEP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
`ifdef SHIFT_ROTATE_EN
    ROT_A = 3'd3,
    ROT_B = 3'd4,
`endif
    DONE  = 3'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  op_r, op_nxt_s;
  logic [4:0]  rem_r, rem_nxt_s;
  logic [31:0] acc_r, acc_nxt_s;
  logic [31:0] rsp_data_r, rsp_data_nxt_s;
  logic [4:0]  step_s, rem_left_s;
  logic [1:0]  sh_ctrl_s;
  logic [4:0]  sh_shamt_s;
  logic [31:0] sh_in_s;
`ifdef SHIFT_ROTATE_EN
  logic [31:0] orig_r, orig_nxt_s;
  logic [31:0] tmp_r, tmp_nxt_s;
  logic [4:0]  n_r, n_nxt_s;
`endif

  // Per-cycle chunk size and the amount left after this chunk.
  always_comb begin
    if (rem_r > STEP_MAX) begin
      step_s = STEP_MAX;
    end else begin
      step_s = rem_r;
    end
    rem_left_s = rem_r - step_s;
  end

  // Next-state, datapath updates and shifter drive.
  always_comb begin
    state_nxt_s    = state_r;
    op_nxt_s       = op_r;
    rem_nxt_s      = rem_r;
    acc_nxt_s      = acc_r;
    rsp_data_nxt_s = rsp_data_r;
    sh_ctrl_s      = 2'b00;
    sh_shamt_s     = 5'd0;
    sh_in_s        = acc_r;
`ifdef SHIFT_ROTATE_EN
    orig_nxt_s     = orig_r;
    tmp_nxt_s      = tmp_r;
    n_nxt_s        = n_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          op_nxt_s  = req_op;
          rem_nxt_s = req_shamt;
          acc_nxt_s = req_data;
          if (req_shamt == 5'd0) begin
            state_nxt_s    = DONE;
            rsp_data_nxt_s = req_data;
          end else if (req_op == 2'b11) begin
`ifdef SHIFT_ROTATE_EN
            state_nxt_s = ROT_A;
            orig_nxt_s  = req_data;
            n_nxt_s     = req_shamt;
`else
            state_nxt_s    = DONE;
            rsp_data_nxt_s = req_data;
`endif
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        sh_ctrl_s  = op_r;
        sh_shamt_s = step_s;
        sh_in_s    = acc_r;
        acc_nxt_s  = sh_out;
        rem_nxt_s  = rem_left_s;
        if (rem_left_s == 5'd0) begin
          state_nxt_s    = DONE;
          rsp_data_nxt_s = sh_out;
        end else begin
          state_nxt_s = RUN;
        end
      end
`ifdef SHIFT_ROTATE_EN
      // Rotate = (x >> n) | (x << (32-n)); the right half is built first in acc.
      ROT_A: begin
        sh_ctrl_s  = 2'b01;
        sh_shamt_s = step_s;
        sh_in_s    = acc_r;
        acc_nxt_s  = sh_out;
        if (rem_left_s == 5'd0) begin
          state_nxt_s = ROT_B;
          rem_nxt_s   = 5'(6'd32 - {1'b0, n_r});
          tmp_nxt_s   = orig_r;
        end else begin
          state_nxt_s = ROT_A;
          rem_nxt_s   = rem_left_s;
        end
      end
      ROT_B: begin
        sh_ctrl_s  = 2'b00;
        sh_shamt_s = step_s;
        sh_in_s    = tmp_r;
        tmp_nxt_s  = sh_out;
        rem_nxt_s  = rem_left_s;
        if (rem_left_s == 5'd0) begin
          state_nxt_s    = DONE;
          rsp_data_nxt_s = acc_r | sh_out;
        end else begin
          state_nxt_s = ROT_B;
        end
      end
`endif
      DONE: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r       <= 2'b00;
      rem_r      <= 5'd0;
      acc_r      <= 32'd0;
      rsp_data_r <= 32'd0;
    end else begin
      op_r       <= op_nxt_s;
      rem_r      <= rem_nxt_s;
      acc_r      <= acc_nxt_s;
      rsp_data_r <= rsp_data_nxt_s;
    end
  end

`ifdef SHIFT_ROTATE_EN
  // Rotate-only registers: original operand, left-shift partial and amount.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      orig_r <= 32'd0;
      tmp_r  <= 32'd0;
      n_r    <= 5'd0;
    end else begin
      orig_r <= orig_nxt_s;
      tmp_r  <= tmp_nxt_s;
      n_r    <= n_nxt_s;
    end
  end
`endif

  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign rsp_valid = (state_r == DONE);
  assign rsp_data  = rsp_data_r;
  assign sh_ctrl   = sh_ctrl_s;
  assign sh_shamt  = sh_shamt_s;
  assign sh_in     = sh_in_s;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural shifter and reference model.
// Honours SHIFT_ROTATE_EN to select the expected op 11 behaviour.
module tb_shift_sequencer;
  localparam int M = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [4:0]  req_shamt = 5'd0;
  logic [31:0] req_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;
  logic [1:0]  sh_ctrl;
  logic [4:0]  sh_shamt;
  logic [31:0] sh_in;
  logic [31:0] sh_out;

  int errors = 0;
  int checks = 0;
  int exp_steps[$];

  shift_sequencer #(.MAX_STEP(M)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_shamt(req_shamt), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .sh_ctrl(sh_ctrl), .sh_shamt(sh_shamt), .sh_in(sh_in), .sh_out(sh_out)
  );

  always #5 clk = ~clk;

  // Combinational shift unit the sequencer drives.
  always_comb begin
    case (sh_ctrl)
      2'b00:   sh_out = sh_in << sh_shamt;
      2'b01:   sh_out = sh_in >> sh_shamt;
      2'b10:   sh_out = $unsigned($signed(sh_in) >>> sh_shamt);
      default: sh_out = sh_in;
    endcase
  end

  function automatic logic [31:0] model_result(logic [1:0] op, int n, logic [31:0] d);
    if (n == 0) return d;
    case (op)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      2'b10:   return $unsigned($signed(d) >>> n);
`ifdef SHIFT_ROTATE_EN
      default: return (d >> n) | (d << (32 - n));
`else
      default: return d;
`endif
    endcase
  endfunction

  function automatic int ceil_div(int a);
    return (a + M - 1) / M;
  endfunction

  function automatic int model_k(logic [1:0] op, int n);
    if (n == 0) return 0;
    if (op != 2'b11) return ceil_div(n);
`ifdef SHIFT_ROTATE_EN
    return ceil_div(n) + ceil_div(32 - n);
`else
    return 0;
`endif
  endfunction

  task automatic add_chunks(input int total);
    int t;
    t = total;
    while (t > 0) begin
      exp_steps.push_back((t > M) ? M : t);
      t -= M;
    end
  endtask

  task automatic model_steps(input logic [1:0] op, input int n);
    exp_steps.delete();
    if (n != 0) begin
      if (op != 2'b11) begin
        add_chunks(n);
      end else begin
`ifdef SHIFT_ROTATE_EN
        add_chunks(n);
        add_chunks(32 - n);
`endif
      end
    end
  endtask

  // One transaction: request, latency/step/result checks, optional stall and intruding request.
  task automatic drive_txn(input logic [1:0] op, input logic [4:0] shamt, input logic [31:0] data,
                           input logic [31:0] exp_data, input int exp_k, input int stall,
                           input logic intrude, input logic [1:0] i_op, input logic [4:0] i_shamt,
                           input logic [31:0] i_data);
    int cyc;
    int got_steps[$];
    logic [31:0] held;
    bit steps_ok;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_req_ready: got %b want 1", req_ready);
    end
    req_op = op; req_shamt = shamt; req_data = data; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      got_steps.push_back(int'(sh_shamt));
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != exp_k) begin
      errors++; $display("FAIL latency op=%0d n=%0d: got %0d want %0d", op, shamt, cyc, exp_k);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp_data) begin
      errors++;
      $display("FAIL rsp_data op=%0d n=%0d d=%h: got %h (valid %b) want %h", op, shamt, data, rsp_data, rsp_valid, exp_data);
    end
    model_steps(op, int'(shamt));
    steps_ok = (got_steps.size() == exp_steps.size());
    if (steps_ok) begin
      foreach (exp_steps[i]) if (got_steps[i] != exp_steps[i]) steps_ok = 1'b0;
    end
    checks++;
    if (!steps_ok) begin
      errors++; $display("FAIL sh_shamt_seq op=%0d n=%0d: got %0d steps want %0d", op, shamt, got_steps.size(), exp_steps.size());
    end
    held = rsp_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (intrude) begin
        req_valid = 1'b1; req_op = i_op; req_shamt = i_shamt; req_data = i_data;
      end
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== held) begin
        errors++;
        $display("FAIL stall_hold: ready=%b valid=%b data=%h want ready=0 valid=1 data=%h", req_ready, rsp_valid, rsp_data, held);
      end
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL handshake_exit: valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || busy !== 1'b0 ||
        sh_ctrl !== 2'b00 || sh_shamt !== 5'd0 || sh_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h busy=%b ctrl=%b shamt=%0d in=%h", req_ready, rsp_valid, rsp_data, busy, sh_ctrl, sh_shamt, sh_in);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    drive_txn(2'b00, 5'd3,  32'h0000000A, 32'h00000050, 1, 0, 1'b0, 2'b00, 5'd0, 32'd0);
    drive_txn(2'b01, 5'd31, 32'hFFFFFFEF, 32'h00000001, 4, 0, 1'b0, 2'b00, 5'd0, 32'd0);
    drive_txn(2'b10, 5'd10, 32'hFFFFFFEF, 32'hFFFFFFFF, 2, 0, 1'b0, 2'b00, 5'd0, 32'd0);
    drive_txn(2'b00, 5'd0,  32'h12345678, 32'h12345678, 0, 0, 1'b0, 2'b00, 5'd0, 32'd0);
    drive_txn(2'b00, 5'd8,  32'h000000FF, 32'h0000FF00, 1, 0, 1'b0, 2'b00, 5'd0, 32'd0);
    drive_txn(2'b10, 5'd31, 32'h80000000, 32'hFFFFFFFF, 4, 0, 1'b0, 2'b00, 5'd0, 32'd0);
  endtask

  task automatic test_rotate();
`ifdef SHIFT_ROTATE_EN
    drive_txn(2'b11, 5'd1, 32'h0000000B, 32'h80000005, 5, 0, 1'b0, 2'b00, 5'd0, 32'd0);
    drive_txn(2'b11, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 1'b0, 2'b00, 5'd0, 32'd0);
`else
    drive_txn(2'b11, 5'd1, 32'h0000000B, 32'h0000000B, 0, 0, 1'b0, 2'b00, 5'd0, 32'd0);
`endif
  endtask

  task automatic test_backpressure();
    drive_txn(2'b01, 5'd4, 32'hF0000000, 32'h0F000000, 1, 3, 1'b1, 2'b00, 5'd9, 32'h00000003);
    drive_txn(2'b00, 5'd9, 32'h00000003, 32'h00000600, 2, 0, 1'b0, 2'b00, 5'd0, 32'd0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    req_op = 2'b01; req_shamt = 5'd31; req_data = 32'hFFFFFFEF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || busy !== 1'b0 ||
        sh_ctrl !== 2'b00 || sh_shamt !== 5'd0 || sh_in !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset: rdy=%b vld=%b data=%h busy=%b ctrl=%b shamt=%0d in=%h", req_ready, rsp_valid, rsp_data, busy, sh_ctrl, sh_shamt, sh_in);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL no_rsp_after_reset: valid=%b busy=%b want 0 0", rsp_valid, busy);
      end
    end
    drive_txn(2'b00, 5'd1, 32'h00000001, 32'h00000002, 1, 0, 1'b0, 2'b00, 5'd0, 32'd0);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [4:0]  n;
    logic [31:0] d;
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      n  = 5'($urandom_range(0, 31));
      d  = $urandom;
      drive_txn(op, n, d, model_result(op, int'(n), d), model_k(op, int'(n)),
                int'($urandom_range(0, 2)), 1'b0, 2'b00, 5'd0, 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rotate();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
